sortnet_feeder: RTL and testbench

//   Packs a serial record stream (one DATW-bit record per cycle) into the 2^P_LOG-lane

---
 rtl/sortnet_pkg.sv | 27 ++
 rtl/sortnet_lane_reg.sv | 35 +++
 rtl/sortnet_feeder.sv | 70 +++++++
 tb/tb_sortnet_feeder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sortnet_pkg.sv
// Shared definitions for the mergesort network feeder and unpacker:
// lane count, block-count width and the max-key pad record.
package sortnet_pkg;

    // The widest record the pad helper can describe.
    localparam int SORTNET_MAX_DATW = 4096;

    function automatic int sortnet_lanes(input int p_log);
        return 1 << p_log;
    endfunction

    // The count is one bit wider than a lane index so that a full block (N) fits.
    function automatic int sortnet_cnt_width(input int p_log);
        return p_log + 1;
    endfunction

    // Pad record: zero payload with an all-ones key, so pads sort to the top lanes.
    function automatic logic [SORTNET_MAX_DATW-1:0] sortnet_pad(input int datw, input int keyw);
        logic [SORTNET_MAX_DATW-1:0] pad;
        pad = '0;
        for (int i = 0; i < keyw; i++) begin
            if (i < datw) pad[i] = 1'b1;
        end
        return pad;
    endfunction

endpackage

// File: rtl/sortnet_lane_reg.sv
// One lane of the feeder block: holds the record written to this lane and
// produces the registered output lane, padded when the lane lies beyond the count.
module sortnet_lane_reg
    import sortnet_pkg::*;
#(
    parameter int DATW = 64,
    parameter int KEYW = 32,
    parameter int CNTW = 5,
    parameter int LANE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic            emit,
    input  logic [DATW-1:0] din,
    input  logic [CNTW-1:0] cnt,
    output logic [DATW-1:0] lane
);

    localparam logic [DATW-1:0] PAD = DATW'(sortnet_pad(DATW, KEYW));

    logic [DATW-1:0] held;

    // A record arriving in the closing cycle bypasses the holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
            lane <= '0;
        end else begin
            if (wr) held <= din;
            if (emit) lane <= (CNTW'(LANE) < cnt) ? (wr ? din : held) : PAD;
        end
    end

endmodule

// File: rtl/sortnet_feeder.sv
// Packs a serial record stream into N-lane blocks for the odd-even mergesort
// network, closing partial blocks on DINLAST/FLUSH and padding with max-key records.
module sortnet_feeder
    import sortnet_pkg::*;
#(
    parameter int P_LOG = 4,
    parameter int DATW  = 64,
    parameter int KEYW  = 32
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [DATW-1:0]                     DIN,
    input  logic                                DINEN,
    input  logic                                DINLAST,
    input  logic                                FLUSH,
    output logic [(DATW<<P_LOG)-1:0]            DOT,
    output logic                                DOTEN,
    output logic [sortnet_cnt_width(P_LOG)-1:0] DOTCNT
);

    localparam int N  = sortnet_lanes(P_LOG);
    localparam int CW = sortnet_cnt_width(P_LOG);

    logic [P_LOG-1:0] lc;
    logic             lc_full;
    logic             close;
    logic [CW-1:0]    next_cnt;

    assign lc_full  = (lc == '1);
    assign close    = (DINEN & (lc_full | DINLAST)) | (FLUSH & ((lc != '0) | DINEN));
    assign next_cnt = CW'(lc) + CW'(DINEN);

    // lc cannot wrap without closing: a record in the top lane always closes the block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lc     <= '0;
            DOTEN  <= 1'b0;
            DOTCNT <= '0;
        end else begin
            DOTEN <= close;
            if (close) begin
                DOTCNT <= next_cnt;
                lc     <= '0;
            end else if (DINEN) begin
                lc <= lc + P_LOG'(1);
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic wr;
        assign wr = DINEN & (lc == P_LOG'(j));

        sortnet_lane_reg #(
            .DATW (DATW),
            .KEYW (KEYW),
            .CNTW (CW),
            .LANE (j)
        ) u_lane (
            .clk  (CLK),
            .rst  (RST),
            .wr   (wr),
            .emit (close),
            .din  (DIN),
            .cnt  (next_cnt),
            .lane (DOT[DATW*j +: DATW])
        );
    end

endmodule

// File: tb/tb_sortnet_feeder.sv
// Self-checking bench for sortnet_feeder (N=4, 16-bit records, 8-bit keys):
// directed vector table, hand-written reset sequence and a randomized stream against a block model.
module tb_sortnet_feeder;

    localparam int P_LOG = 2;
    localparam int DATW  = 16;
    localparam int KEYW  = 8;
    localparam int N     = 1 << P_LOG;
    localparam logic [DATW-1:0] PAD = {{(DATW-KEYW){1'b0}}, {KEYW{1'b1}}};

    logic                CLK;
    logic                RST;
    logic [DATW-1:0]     DIN;
    logic                DINEN;
    logic                DINLAST;
    logic                FLUSH;
    logic [DATW*N-1:0]   DOT;
    logic                DOTEN;
    logic [P_LOG:0]      DOTCNT;

    int checks = 0;
    int errors = 0;

    // Reference model: the records of the open block, oldest first, plus the held outputs.
    logic [DATW-1:0]   blk[$];
    logic              m_en  = 1'b0;
    logic [P_LOG:0]    m_cnt = '0;
    logic [DATW*N-1:0] m_dot = '0;

    typedef struct {
        logic            rst;
        logic            en;
        logic            last;
        logic            flush;
        logic [DATW-1:0] din;
        logic            exp_en;
        logic [P_LOG:0]  exp_cnt;
        logic [DATW*N-1:0] exp_dot;
        string           name;
    } vec_t;

    vec_t vecs[$];

    sortnet_feeder #(
        .P_LOG (P_LOG),
        .DATW  (DATW),
        .KEYW  (KEYW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .DIN     (DIN),
        .DINEN   (DINEN),
        .DINLAST (DINLAST),
        .FLUSH   (FLUSH),
        .DOT     (DOT),
        .DOTEN   (DOTEN),
        .DOTCNT  (DOTCNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic exp_en,
                               input logic [P_LOG:0] exp_cnt, input logic [DATW*N-1:0] exp_dot);
        checks++;
        if (DOTEN !== exp_en) begin
            errors++;
            $display("[TB] FAIL %s DOTEN: got %b, expected %b", name, DOTEN, exp_en);
        end
        checks++;
        if (DOTCNT !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL %s DOTCNT: got %0d, expected %0d", name, DOTCNT, exp_cnt);
        end
        checks++;
        if (DOT !== exp_dot) begin
            errors++;
            $display("[TB] FAIL %s DOT: got %h, expected %h", name, DOT, exp_dot);
        end
    endtask

    task automatic modelStep(input logic rst, input logic en, input logic last,
                             input logic flush, input logic [DATW-1:0] din);
        if (rst) begin
            blk.delete();
            m_en  = 1'b0;
            m_cnt = '0;
            m_dot = '0;
        end else begin
            if (en) blk.push_back(din);
            m_en = (en && (blk.size() == N || last)) || (flush && blk.size() > 0);
            if (m_en) begin
                m_cnt = (P_LOG+1)'(blk.size());
                for (int j = 0; j < N; j++)
                    m_dot[DATW*j +: DATW] = (j < blk.size()) ? blk[j] : PAD;
                blk.delete();
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then compare against the model.
    task automatic applyStimulus(input logic rst, input logic en, input logic last,
                                 input logic flush, input logic [DATW-1:0] din, input string name);
        RST = rst; DINEN = en; DINLAST = last; FLUSH = flush; DIN = din;
        @(posedge CLK);
        #1;
        modelStep(rst, en, last, flush, din);
        checkOutput({name, "/model"}, m_en, m_cnt, m_dot);
    endtask

    task automatic addVec(input logic rst, input logic en, input logic last, input logic flush,
                          input logic [DATW-1:0] din, input logic exp_en,
                          input logic [P_LOG:0] exp_cnt, input logic [DATW*N-1:0] exp_dot,
                          input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.last = last; v.flush = flush; v.din = din;
        v.exp_en = exp_en; v.exp_cnt = exp_cnt; v.exp_dot = exp_dot; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        logic [DATW-1:0] d;

        RST = 1'b1; DINEN = 1'b0; DINLAST = 1'b0; FLUSH = 1'b0; DIN = '0;

        //     rst en  lst flu din       en  cnt  dot
        addVec(1, 0, 0, 0, 16'h0000, 0, 0, 64'h0, "reset0");
        addVec(1, 0, 0, 0, 16'h0000, 0, 0, 64'h0, "reset1");
        addVec(1, 0, 0, 0, 16'h0000, 0, 0, 64'h0, "reset2");
        addVec(0, 1, 0, 0, 16'h0004, 0, 0, 64'h0, "full_r0");
        addVec(0, 1, 0, 0, 16'h0003, 0, 0, 64'h0, "full_r1");
        addVec(0, 1, 0, 0, 16'h0002, 0, 0, 64'h0, "full_r2");
        addVec(0, 1, 0, 0, 16'h0001, 1, 4, 64'h0001_0002_0003_0004, "full_emit");
        addVec(0, 1, 0, 0, 16'h0011, 0, 4, 64'h0001_0002_0003_0004, "last_r0");
        addVec(0, 1, 1, 0, 16'h0022, 1, 2, 64'h00FF_00FF_0022_0011, "last_emit");
        addVec(0, 1, 0, 0, 16'h0A01, 0, 2, 64'h00FF_00FF_0022_0011, "flush_r0");
        addVec(0, 1, 0, 0, 16'h0A02, 0, 2, 64'h00FF_00FF_0022_0011, "flush_r1");
        addVec(0, 1, 0, 0, 16'h0A03, 0, 2, 64'h00FF_00FF_0022_0011, "flush_r2");
        addVec(0, 0, 0, 0, 16'h0000, 0, 2, 64'h00FF_00FF_0022_0011, "flush_idle");
        addVec(0, 0, 0, 1, 16'h0000, 1, 3, 64'h00FF_0A03_0A02_0A01, "flush_emit");
        addVec(0, 0, 0, 1, 16'h0000, 0, 3, 64'h00FF_0A03_0A02_0A01, "flush_empty");
        addVec(0, 1, 1, 0, 16'h0101, 1, 1, 64'h00FF_00FF_00FF_0101, "b2b_0");
        addVec(0, 1, 1, 0, 16'h0102, 1, 1, 64'h00FF_00FF_00FF_0102, "b2b_1");
        addVec(0, 1, 1, 0, 16'h0103, 1, 1, 64'h00FF_00FF_00FF_0103, "b2b_2");
        addVec(0, 1, 1, 0, 16'h0104, 1, 1, 64'h00FF_00FF_00FF_0104, "b2b_3");
        addVec(0, 1, 1, 0, 16'h0105, 1, 1, 64'h00FF_00FF_00FF_0105, "b2b_4");
        addVec(0, 1, 0, 0, 16'h0D01, 0, 1, 64'h00FF_00FF_00FF_0105, "lastflush_r0");
        addVec(0, 1, 1, 1, 16'h0D02, 1, 2, 64'h00FF_00FF_0D02_0D01, "lastflush_emit");
        addVec(0, 0, 0, 0, 16'h0000, 0, 2, 64'h00FF_00FF_0D02_0D01, "lastflush_idle");
        addVec(0, 1, 0, 1, 16'h0E01, 1, 1, 64'h00FF_00FF_00FF_0E01, "flush_with_en");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].last, vecs[i].flush, vecs[i].din, vecs[i].name);
            checkOutput(vecs[i].name, vecs[i].exp_en, vecs[i].exp_cnt, vecs[i].exp_dot);
        end

        // Mid-block reset discards the partial block, even with DINEN and FLUSH asserted.
        applyStimulus(0, 1, 0, 0, 16'h0B01, "rst_mid_r0");
        applyStimulus(0, 1, 0, 0, 16'h0B02, "rst_mid_r1");
        applyStimulus(1, 1, 0, 1, 16'h0B03, "rst_mid_rst");
        checkOutput("rst_mid_cleared", 1'b0, 3'd0, 64'h0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 16'h0C01 + 16'(i), "rst_mid_post");
            if (DOTEN) pulses++;
        end
        checkOutput("rst_mid_emit", 1'b1, 3'd4, 64'h0C04_0C03_0C02_0C01);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 16'h0000, "rst_mid_idle");
            if (DOTEN) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL rst_mid_pulses: got %0d pulses, expected 1", pulses);
        end

        // Random stream; real keys avoid the all-ones pad key.
        for (int i = 0; i < 600; i++) begin
            d = DATW'($urandom);
            if (d[KEYW-1:0] == '1) d[0] = 1'b0;
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
                          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10, d, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
